platform_field: RTL

Parametrised platform store and pixel matcher for the Doodle Jump video path. Holds `NUM_PLAT` platform slots with LFSR-randomised X positions and evenly spaced Y positions. Scrolls all slots downward on each frame tick and respawns any slot that leaves the bottom of the screen at the top with a fresh random X. Answers a registered "is this pixel a platform, and which one" query for the colour mapper.

---
 rtl/platform_pkg.sv | 32 +++
 rtl/platform_field_if.sv | 27 ++
 rtl/platform_field_lfsr.sv | 22 ++
 rtl/platform_field.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/platform_pkg.sv
// Shared types and helpers for the platform field.
// Slot record, FSM states, LFSR taps and load-time Y layout.
package platform_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCROLL
  } plat_state_e;

  typedef struct packed {
    logic               valid;
    logic [9:0]         x;
    logic signed [10:0] y;
  } plat_slot_t;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Centre Y of a slot right after a load; slot 0 sits lowest
  function automatic logic signed [10:0] slot_y0(
    input int idx,
    input int screen_h,
    input int half_h,
    input int spacing
  );
    int v;
    v = screen_h - 1 - half_h - idx * spacing;
    return 11'(v);
  endfunction

endpackage

// File: rtl/platform_field_if.sv
// Control and pixel-query bundle of the platform field.
// The video side drives requests/queries, the field answers.
interface platform_field_if #(
  parameter int IDX_W = 4
);
  logic             frame_clk;
  logic [4:0]       scroll_amt;
  logic             load_req;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic             busy;
  logic             load_done;
  logic             plat_on;
  logic [IDX_W-1:0] plat_idx;

  modport master (
    output frame_clk, scroll_amt, load_req,
    output DrawX, DrawY,
    input  busy, load_done, plat_on, plat_idx
  );

  modport slave (
    input  frame_clk, scroll_amt, load_req,
    input  DrawX, DrawY,
    output busy, load_done, plat_on, plat_idx
  );
endinterface

// File: rtl/platform_field_lfsr.sv
// Free-running Galois LFSR used for platform X positions.
// Shifts right every cycle, XORing the taps when bit 0 is set.
module lfsr_gen #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED = 16'hACE1,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q
);

  // advance one step per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else begin
      q <= {1'b0, q[WIDTH-1:1]} ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/platform_field.sv
// Platform slot store with load/scroll FSM and pixel matcher.
// Scroll requests accumulate while busy and are served from IDLE.
module platform_field
  import platform_pkg::*;
#(
  parameter int          NUM_PLAT    = 16,
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480,
  parameter int          PLAT_HALF_W = 16,
  parameter int          PLAT_HALF_H = 4,
  parameter int          SPACING     = 30,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic            Clk,
  input  logic            Reset_n,
  platform_field_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_PLAT);
  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic signed [11:0] YMAX_S =
    12'(SCREEN_H - 1 + PLAT_HALF_H);
  localparam logic signed [11:0] WRAP_S =
    12'(NUM_PLAT * SPACING);
  localparam logic signed [11:0] HW = 12'(PLAT_HALF_W);
  localparam logic signed [11:0] HH = 12'(PLAT_HALF_H);

  logic [15:0]      rnd;
  logic             unused_rnd;
  logic [9:0]       rand_x;
  plat_slot_t       slot [NUM_PLAT];
  plat_state_e      state;
  logic [IDX_W-1:0] idx;
  logic [5:0]       acc;
  logic [5:0]       amt;
  logic             pend;
  logic             frame_q;
  logic             rise;
  logic             consume;
  logic             last;
  logic [6:0]       sum;
  logic [5:0]       acc_sat;
  logic signed [11:0] ycur;
  logic signed [11:0] ynew;
  logic signed [11:0] yresp;
  logic             respawn;
  logic             busy_q;
  logic             done_q;
  logic             on_q;
  logic [IDX_W-1:0] pidx_q;
  logic [NUM_PLAT-1:0] hit;
  logic             any_hit;
  logic [IDX_W-1:0] sel;

  lfsr_gen #(
    .WIDTH(16),
    .SEED (SEED_EFF),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk  (Clk),
    .rst_n(Reset_n),
    .q    (rnd)
  );

  assign unused_rnd = ^rnd[15:9];
  assign rand_x = 10'(PLAT_HALF_W) + {1'b0, rnd[8:0]};

  assign rise    = bus.frame_clk & ~frame_q;
  assign consume = (state == IDLE) & ~bus.load_req & pend;
  assign last    = (idx == IDX_W'(NUM_PLAT - 1));
  assign sum     = {1'b0, acc} + {2'b00, bus.scroll_amt};
  assign acc_sat = sum[6] ? 6'h3F : sum[5:0];

  assign ycur    = {slot[idx].y[10], slot[idx].y};
  assign ynew    = ycur + $signed({6'b0, amt});
  assign yresp   = ynew - WRAP_S;
  assign respawn = ynew > YMAX_S;

  // frame tick edge detect and saturating scroll accumulator
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_q <= 1'b0;
      acc     <= '0;
      pend    <= 1'b0;
    end else begin
      frame_q <= bus.frame_clk;
      if (rise) begin
        pend <= 1'b1;
        acc  <= consume ? {1'b0, bus.scroll_amt} : acc_sat;
      end else if (consume) begin
        pend <= 1'b0;
        acc  <= '0;
      end
    end
  end

  // load/scroll sequencer, one slot per cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      amt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < NUM_PLAT; i++) begin
        slot[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load_req) begin
            state  <= LOAD;
            idx    <= '0;
            busy_q <= 1'b1;
          end else if (pend) begin
            state  <= SCROLL;
            idx    <= '0;
            amt    <= acc;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          slot[idx] <= '{
            valid: 1'b1,
            x:     rand_x,
            y:     slot_y0(int'(idx), SCREEN_H,
                           PLAT_HALF_H, SPACING)
          };
          if (last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SCROLL: begin
          if (slot[idx].valid) begin
            if (respawn) begin
              slot[idx].y <= yresp[10:0];
              slot[idx].x <= rand_x;
            end else begin
              slot[idx].y <= ynew[10:0];
            end
          end
          if (last) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PLAT; g++) begin : g_match
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    assign dx = $signed({2'b00, bus.DrawX})
              - $signed({2'b00, slot[g].x});
    assign dy = $signed({2'b00, bus.DrawY})
              - $signed({slot[g].y[10], slot[g].y});
    assign hit[g] = slot[g].valid
                  & (dx <= HW) & (dx >= -HW)
                  & (dy <= HH) & (dy >= -HH);
  end

  // lowest matching slot wins
  always_comb begin
    any_hit = 1'b0;
    sel     = '0;
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        sel     = IDX_W'(i);
      end
    end
  end

  // register the pixel answer for one-cycle latency
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      on_q   <= 1'b0;
      pidx_q <= '0;
    end else begin
      on_q   <= any_hit;
      pidx_q <= sel;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.load_done = done_q;
  assign bus.plat_on   = on_q;
  assign bus.plat_idx  = pidx_q;

endmodule
